// File: rtl/even_pipe_pkg.sv
// even_pipe_pkg
// Shared definitions for the even pipe: the layout of the 143-bit packed
// stage word, functional-unit codes and the pipeline depth.
//
// Packed word layout (bit 0 is the MSB):
//   [0:2]    unit_id
//   [3:9]    reg_dst
//   [10]     reg_wr
//   [11:14]  latency
//   [15:142] result
package even_pipe_pkg;

    localparam int PIPE_DEPTH = 7;

    localparam int UNIT_W     = 3;
    localparam int REG_ADDR_W = 7;
    localparam int LAT_W      = 4;
    localparam int DATA_W     = 128;
    localparam int WORD_W     = UNIT_W + REG_ADDR_W + 1 + LAT_W + DATA_W;

    localparam int UNIT_OFS    = 0;
    localparam int REG_DST_OFS = UNIT_OFS + UNIT_W;
    localparam int REG_WR_OFS  = REG_DST_OFS + REG_ADDR_W;
    localparam int LAT_OFS     = REG_WR_OFS + 1;
    localparam int RESULT_OFS  = LAT_OFS + LAT_W;

    localparam logic [0:UNIT_W-1] UNIT_FX1 = 3'b000;

    typedef logic [0:WORD_W-1] packed_word_t;
    typedef logic [0:DATA_W-1] data_t;

    // Assembles one stage word from its fields using the offsets above so the
    // layout is defined in exactly one place.
    function automatic packed_word_t pack_word(
        input logic [0:UNIT_W-1]     unit_id,
        input logic [0:REG_ADDR_W-1] reg_dst,
        input logic                  reg_wr,
        input logic [0:LAT_W-1]      latency,
        input data_t                 result
    );
        packed_word_t word;
        word = '0;
        word[UNIT_OFS    +: UNIT_W]     = unit_id;
        word[REG_DST_OFS +: REG_ADDR_W] = reg_dst;
        word[REG_WR_OFS]                = reg_wr;
        word[LAT_OFS     +: LAT_W]      = latency;
        word[RESULT_OFS  +: DATA_W]     = result;
        return word;
    endfunction

endpackage

// File: rtl/even_pipe_fx1_alu.sv
// fx1_alu
// Simple fixed-point unit of the even pipe: the result is ra + rb, wrapping
// modulo 2^128, regardless of the opcode. The remaining operands are wired
// in so the unit can grow without touching the top level.
//
// Ports:
//   instr_id  in  7    decoded opcode ID (not decoded yet)
//   ra, rb    in  128  addends
//   rc        in  128  third operand (not used yet)
//   imme7/10/16/18 in  immediates (not used yet)
//   result    out 128  ra + rb
module fx1_alu
    import even_pipe_pkg::*;
(
    input  logic [0:6]        instr_id,
    input  logic [0:DATA_W-1] ra,
    input  logic [0:DATA_W-1] rb,
    input  logic [0:DATA_W-1] rc,
    input  logic [0:7]        imme7,
    input  logic [0:9]        imme10,
    input  logic [0:15]       imme16,
    input  logic [0:17]       imme18,
    output logic [0:DATA_W-1] result
);

    // Operands kept for future opcodes; folded together so they are visibly
    // consumed.
    logic unused_operands;
    assign unused_operands = ^{instr_id, rc, imme7, imme10, imme16, imme18};

    // Carry out of bit 0 is intentionally dropped.
    assign result = ra + rb;

endmodule

// File: rtl/even_pipe.sv
// even_pipe
// Seven-stage even execution pipe. Each cycle the incoming instruction's
// control fields and its functional-unit result are packed into one 143-bit
// word and shifted down a fixed 7-entry register chain. Every stage is
// exposed for operand forwarding; stage 7 drives the register-file write port.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   full_isntr              full instruction word (reserved)
//   instr_id, imme*         forwarded to the functional unit
//   reg_dst, unit_id, latency, reg_wr   control fields carried down the pipe
//   ra_data, rb_data, rc_data           source operands
//   packed_result_Nstage    contents of stage N (N = 1..7)
//   WB_reg_write_*          write-back port taken from stage 7
module even_pipe
    import even_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:31]           full_isntr,
    input  logic [0:6]            instr_id,
    input  logic [0:REG_ADDR_W-1] reg_dst,
    input  logic [0:UNIT_W-1]     unit_id,
    input  logic [0:LAT_W-1]      latency,
    input  logic                  reg_wr,
    input  logic [0:DATA_W-1]     ra_data,
    input  logic [0:DATA_W-1]     rb_data,
    input  logic [0:DATA_W-1]     rc_data,
    input  logic [0:7]            imme7,
    input  logic [0:9]            imme10,
    input  logic [0:15]           imme16,
    input  logic [0:17]           imme18,
    output logic [0:WORD_W-1]     packed_result_1stage,
    output logic [0:WORD_W-1]     packed_result_2stage,
    output logic [0:WORD_W-1]     packed_result_3stage,
    output logic [0:WORD_W-1]     packed_result_4stage,
    output logic [0:WORD_W-1]     packed_result_5stage,
    output logic [0:WORD_W-1]     packed_result_6stage,
    output logic [0:WORD_W-1]     packed_result_7stage,
    output logic [0:REG_ADDR_W-1] WB_reg_write_addr,
    output logic [0:DATA_W-1]     WB_reg_write_data,
    output logic                  WB_reg_write_en
);

    data_t        fx1_result;
    data_t        unit_result;
    packed_word_t in_word;
    packed_word_t stage_q [PIPE_DEPTH];

    // The full instruction word is reserved and has no effect.
    logic unused_instr;
    assign unused_instr = ^full_isntr;

    fx1_alu u_fx1_alu (
        .instr_id (instr_id),
        .ra       (ra_data),
        .rb       (rb_data),
        .rc       (rc_data),
        .imme7    (imme7),
        .imme10   (imme10),
        .imme16   (imme16),
        .imme18   (imme18),
        .result   (fx1_result)
    );

    // Only FX1 exists so far; any other unit code yields a zero result while
    // its control fields still travel down the pipe.
    always_comb begin
        unit_result = '0;
        if (unit_id == UNIT_FX1) begin
            unit_result = fx1_result;
        end
        in_word = pack_word(unit_id, reg_dst, reg_wr, latency, unit_result);
    end

    // Free-running shift chain: no stall, every stage advances each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_word;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign packed_result_1stage = stage_q[0];
    assign packed_result_2stage = stage_q[1];
    assign packed_result_3stage = stage_q[2];
    assign packed_result_4stage = stage_q[3];
    assign packed_result_5stage = stage_q[4];
    assign packed_result_6stage = stage_q[5];
    assign packed_result_7stage = stage_q[6];

    assign WB_reg_write_addr = stage_q[PIPE_DEPTH-1][REG_DST_OFS +: REG_ADDR_W];
    assign WB_reg_write_data = stage_q[PIPE_DEPTH-1][RESULT_OFS  +: DATA_W];
    assign WB_reg_write_en   = stage_q[PIPE_DEPTH-1][REG_WR_OFS];

endmodule

// File: tb/tb_even_pipe.sv
// tb_even_pipe
// Directed self-checking bench for even_pipe: reset state, FX1 addition and
// wrap-around, stage-by-stage propagation, non-FX1 units, asynchronous reset
// with a full pipe and the first capture after reset release.
module tb_even_pipe;

    logic          clk;
    logic          rst;
    logic [0:31]   full_isntr;
    logic [0:6]    instr_id;
    logic [0:6]    reg_dst;
    logic [0:2]    unit_id;
    logic [0:3]    latency;
    logic          reg_wr;
    logic [0:127]  ra_data;
    logic [0:127]  rb_data;
    logic [0:127]  rc_data;
    logic [0:7]    imme7;
    logic [0:9]    imme10;
    logic [0:15]   imme16;
    logic [0:17]   imme18;
    logic [0:142]  packed_result_1stage;
    logic [0:142]  packed_result_2stage;
    logic [0:142]  packed_result_3stage;
    logic [0:142]  packed_result_4stage;
    logic [0:142]  packed_result_5stage;
    logic [0:142]  packed_result_6stage;
    logic [0:142]  packed_result_7stage;
    logic [0:6]    WB_reg_write_addr;
    logic [0:127]  WB_reg_write_data;
    logic          WB_reg_write_en;

    logic [0:142]  stage_obs [1:7];
    logic [0:142]  hist [10];

    int tests_run;
    int tests_failed;

    even_pipe dut (
        .clk                  (clk),
        .rst                  (rst),
        .full_isntr           (full_isntr),
        .instr_id             (instr_id),
        .reg_dst              (reg_dst),
        .unit_id              (unit_id),
        .latency              (latency),
        .reg_wr               (reg_wr),
        .ra_data              (ra_data),
        .rb_data              (rb_data),
        .rc_data              (rc_data),
        .imme7                (imme7),
        .imme10               (imme10),
        .imme16               (imme16),
        .imme18               (imme18),
        .packed_result_1stage (packed_result_1stage),
        .packed_result_2stage (packed_result_2stage),
        .packed_result_3stage (packed_result_3stage),
        .packed_result_4stage (packed_result_4stage),
        .packed_result_5stage (packed_result_5stage),
        .packed_result_6stage (packed_result_6stage),
        .packed_result_7stage (packed_result_7stage),
        .WB_reg_write_addr    (WB_reg_write_addr),
        .WB_reg_write_data    (WB_reg_write_data),
        .WB_reg_write_en      (WB_reg_write_en)
    );

    assign stage_obs[1] = packed_result_1stage;
    assign stage_obs[2] = packed_result_2stage;
    assign stage_obs[3] = packed_result_3stage;
    assign stage_obs[4] = packed_result_4stage;
    assign stage_obs[5] = packed_result_5stage;
    assign stage_obs[6] = packed_result_6stage;
    assign stage_obs[7] = packed_result_7stage;

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference packed word: control fields followed by ra + rb for FX1,
    // zero for any other unit.
    function automatic logic [0:142] makeWord(
        input logic [0:2]   u,
        input logic [0:6]   d,
        input logic         w,
        input logic [0:3]   l,
        input logic [0:127] a,
        input logic [0:127] b
    );
        logic [0:127] r;
        r = (u == 3'b000) ? a + b : 128'h0;
        return {u, d, w, l, r};
    endfunction

    // Drives the fields that matter and scrambles the ones that must not.
    task automatic applyStimulus(
        input logic [0:2]   u,
        input logic [0:6]   d,
        input logic         w,
        input logic [0:3]   l,
        input logic [0:127] a,
        input logic [0:127] b
    );
        unit_id    = u;
        reg_dst    = d;
        reg_wr     = w;
        latency    = l;
        ra_data    = a;
        rb_data    = b;
        rc_data    = {$urandom, $urandom, $urandom, $urandom};
        full_isntr = $urandom;
        instr_id   = 7'($urandom);
        imme7      = 8'($urandom);
        imme10     = 10'($urandom);
        imme16     = 16'($urandom);
        imme18     = 18'($urandom);
    endtask

    task automatic checkOutput(
        input string        tag,
        input logic [0:142] observed,
        input logic [0:142] expected
    );
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Sample one time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        for (int n = 1; n <= 7; n++) begin
            checkOutput($sformatf("%s_stage%0d", tag, n), stage_obs[n], 143'h0);
        end
        checkOutput({tag, "_wb_addr"}, 143'(WB_reg_write_addr), 143'h0);
        checkOutput({tag, "_wb_data"}, 143'(WB_reg_write_data), 143'h0);
        checkOutput({tag, "_wb_en"},   143'(WB_reg_write_en),   143'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held with arbitrary inputs.
        rst = 1'b0;
        applyStimulus(3'b000, 7'h55, 1'b1, 4'hF, {4{32'hDEADBEEF}}, {4{32'h12345678}});
        repeat (3) tick();
        checkAllZero("reset_hold");

        // Constant FX1 instruction, reset released between edges.
        applyStimulus(3'b000, 7'h07, 1'b1, 4'b0010, {16{8'h11}}, {16{8'h22}});
        #3;
        rst = 1'b1;
        tick();
        checkOutput("edge1_stage1", packed_result_1stage,
                    {3'b000, 7'h07, 1'b1, 4'b0010, {16{8'h33}}});
        checkOutput("edge1_stage2", packed_result_2stage, 143'h0);
        repeat (5) tick();
        checkOutput("edge6_wb_en", 143'(WB_reg_write_en), 143'h0);
        tick();
        checkOutput("edge7_wb_addr", 143'(WB_reg_write_addr), 143'(7'h07));
        checkOutput("edge7_wb_data", 143'(WB_reg_write_data), 143'({16{8'h33}}));
        checkOutput("edge7_wb_en",   143'(WB_reg_write_en),   143'(1'b1));

        // Wrapping addition with reg_wr low; old write-back persists 6 edges.
        applyStimulus(3'b000, 7'h71, 1'b0, 4'b0010, {16{8'hAA}}, {16{8'hBB}});
        for (int e = 1; e <= 6; e++) begin
            tick();
            checkOutput($sformatf("wrap_hold_e%0d", e), 143'(WB_reg_write_data),
                        143'({16{8'h33}}));
        end
        tick();
        checkOutput("wrap_wb_data", 143'(WB_reg_write_data), 143'({{31{4'h6}}, 4'h5}));
        checkOutput("wrap_wb_addr", 143'(WB_reg_write_addr), 143'(7'h71));
        checkOutput("wrap_wb_en",   143'(WB_reg_write_en),   143'(1'b0));

        // New vector every cycle; stage N holds the vector from N edges ago.
        for (int i = 0; i < 10; i++) begin
            logic [0:2]   u;
            logic [0:127] a;
            logic [0:127] b;
            u = (i % 3 == 0) ? 3'b011 : ((i % 4 == 1) ? 3'b101 : 3'b000);
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            hist[i] = makeWord(u, 7'(i * 13 + 5), i[0], 4'(i), a, b);
            applyStimulus(u, 7'(i * 13 + 5), i[0], 4'(i), a, b);
            tick();
            for (int n = 1; n <= 7; n++) begin
                if (i - n + 1 >= 0) begin
                    checkOutput($sformatf("shift_v%0d_stage%0d", i, n),
                                stage_obs[n], hist[i-n+1]);
                end
            end
        end

        // Non-FX1 unit: zero result, control fields preserved.
        applyStimulus(3'b011, 7'h2A, 1'b1, 4'b1001, {16{8'h5A}}, {16{8'h01}});
        repeat (7) tick();
        checkOutput("unit3_wb_data", 143'(WB_reg_write_data), 143'h0);
        checkOutput("unit3_wb_addr", 143'(WB_reg_write_addr), 143'(7'h2A));
        checkOutput("unit3_wb_en",   143'(WB_reg_write_en),   143'(1'b1));
        checkOutput("unit3_stage7", packed_result_7stage,
                    {3'b011, 7'h2A, 1'b1, 4'b1001, 128'h0});

        // Asynchronous reset between edges with the pipe full.
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async_reset");

        // First capture happens on the first edge after release.
        applyStimulus(3'b000, 7'h15, 1'b1, 4'b0001, 128'd1, 128'd2);
        tick();
        checkOutput("in_reset_stage1", packed_result_1stage, 143'h0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("release_no_edge_stage1", packed_result_1stage, 143'h0);
        tick();
        checkOutput("release_edge1_stage1", packed_result_1stage,
                    {3'b000, 7'h15, 1'b1, 4'b0001, 128'd3});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
